axi4_stream_initiator_type_1: RTL



---
 rtl/axi4_stream_initiator_type_1_pkg.sv | 38 +++
 rtl/axi4_stream_initiator_type_1_if.sv | 23 ++
 rtl/axi4_stream_initiator_type_1_position_counter.sv | 50 +++++
 rtl/axi4_stream_initiator_type_1.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/axi4_stream_initiator_type_1_pkg.sv
// Shared constants for the AXI4-Stream traffic initiator/target pair: tdata
// pattern, Mode / TlastTrigger string encodings and the FSM state encoding.
package axi4_stream_traffic_pkg;

  localparam logic [47:0] MODE_SINGLE = 48'("SINGLE");
  localparam logic [47:0] MODE_LOOP   = 48'("LOOP");

  localparam logic [63:0] TLAST_NONE     = 64'("NONE");
  localparam logic [63:0] TLAST_TRANSFER = 64'("TRANSFER");
  localparam logic [63:0] TLAST_PACKET   = 64'("PACKET");
  localparam logic [63:0] TLAST_FRAME    = 64'("FRAME");
  localparam logic [63:0] TLAST_STREAM   = 64'("STREAM");

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_PAUSE  = 2'd1,
    ST_DONE   = 2'd2
  } traffic_state_e;

  // First tdata value; the caller truncates or zero-extends to its width.
  function automatic logic [63:0] tdata_init(input int unsigned width);
    if (width <= 8)       return 64'h0000_00A0;
    else if (width <= 16) return 64'h0000_0A00;
    else                  return 64'hABCD_0A00;
  endfunction

  function automatic logic [63:0] tdata_incr(input int unsigned width);
    if (width <= 8)       return 64'h0000_0001;
    else if (width <= 16) return 64'h0000_0101;
    else                  return 64'h0001_0001;
  endfunction

  // Zero-sized packets, frames or streams behave as size one.
  function automatic int unsigned at_least_one(input int unsigned n);
    return (n == 0) ? 1 : n;
  endfunction

endpackage

// File: rtl/axi4_stream_initiator_type_1_if.sv
// AXI4-Stream bundle shared by the traffic initiator and its sink.
interface axi4_stream_initiator_type_1_if #(
  parameter int unsigned TDataWidth = 32,
  parameter int unsigned TIdWidth   = 8,
  parameter int unsigned TDestWidth = 8
);
  logic                  tvalid;
  logic                  tready;
  logic [TDataWidth-1:0] tdata;
  logic                  tlast;
  logic [TIdWidth-1:0]   tid;
  logic [TDestWidth-1:0] tdest;

  modport master (
    output tvalid, tdata, tlast, tid, tdest,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tlast, tid, tdest,
    output tready
  );
endinterface

// File: rtl/axi4_stream_initiator_type_1_position_counter.sv
// Transfer / packet / frame down-counters locating the current transfer in
// its stream; shared by the traffic initiator and target.
module axi4_stream_position_counter
  import axi4_stream_traffic_pkg::*;
#(
  parameter int unsigned TransfersPerPacket = 1,
  parameter int unsigned PacketsPerFrame    = 1,
  parameter int unsigned FramesPerStream    = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic step,
  output logic last_transfer,  // current transfer closes its packet
  output logic last_packet,    // current packet closes its frame
  output logic last_frame,     // current frame closes the stream
  output logic last_stream
);

  localparam logic [31:0] TRANSFER_TOP = 32'(at_least_one(TransfersPerPacket) - 1);
  localparam logic [31:0] PACKET_TOP   = 32'(at_least_one(PacketsPerFrame) - 1);
  localparam logic [31:0] FRAME_TOP    = 32'(at_least_one(FramesPerStream) - 1);

  logic [31:0] transfer_cnt;
  logic [31:0] packet_cnt;
  logic [31:0] frame_cnt;

  assign last_transfer = (transfer_cnt == '0);
  assign last_packet   = (packet_cnt == '0);
  assign last_frame    = (frame_cnt == '0);
  assign last_stream   = last_transfer & last_packet & last_frame;

  // NOTE: state uses non-blocking assignments so every counter samples the
  // pre-edge values of its neighbours, whatever order the statements are in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      transfer_cnt <= TRANSFER_TOP;
      packet_cnt   <= PACKET_TOP;
      frame_cnt    <= FRAME_TOP;
    end else if (step) begin
      transfer_cnt <= last_transfer ? TRANSFER_TOP : transfer_cnt - 32'd1;
      if (last_transfer) begin
        packet_cnt <= last_packet ? PACKET_TOP : packet_cnt - 32'd1;
      end
      if (last_transfer && last_packet) begin
        frame_cnt <= last_frame ? FRAME_TOP : frame_cnt - 32'd1;
      end
    end
  end

endmodule

// File: rtl/axi4_stream_initiator_type_1.sv
// Deterministic AXI4-Stream traffic source with active/pause duty cycling.
// Define AXI4_STREAM_INITIATOR_TYPE_1_DEBUG_DISPLAY_EN to log every transfer.
module axi4_stream_initiator_type_1
  import axi4_stream_traffic_pkg::*;
#(
  parameter int unsigned TDataWidth         = 32,
  parameter int unsigned TIdWidth           = 8,
  parameter int unsigned TDestWidth         = 8,
  parameter int unsigned TId                = 0,
  parameter int unsigned TDest              = 0,
  parameter logic [47:0] Mode               = MODE_LOOP,
  parameter logic [31:0] CyclesActive       = 32'd0,
  parameter logic [31:0] CyclesPause        = 32'd0,
  parameter int unsigned TransfersPerPacket = 1,
  parameter int unsigned PacketsPerFrame    = 1,
  parameter int unsigned FramesPerStream    = 1,
  parameter logic [63:0] TlastTrigger       = TLAST_NONE
) (
  input  logic                  clk_m_axis_i,
  input  logic                  rst_m_axis_ni,
  output logic                  m_axis_tvalid_o,
  input  logic                  m_axis_tready_i,
  output logic [TDataWidth-1:0] m_axis_tdata_o,
  output logic                  m_axis_tlast_o,
  output logic [TIdWidth-1:0]   m_axis_tid_o,
  output logic [TDestWidth-1:0] m_axis_tdest_o,
  output logic                  done_o
);

  localparam logic [TDataWidth-1:0] TDATA_INIT = TDataWidth'(tdata_init(TDataWidth));
  localparam logic [TDataWidth-1:0] TDATA_INCR = TDataWidth'(tdata_incr(TDataWidth));
  localparam logic [TIdWidth-1:0]   TID_INIT   = TIdWidth'(TId);
  localparam bit                    PAUSE_EN   = (CyclesPause != '0);
  localparam bit                    SINGLE_EN  = (Mode == MODE_SINGLE);
  localparam logic [31:0] ACTIVE_TOP = (CyclesActive == '0) ? '0 : CyclesActive - 32'd1;
  localparam logic [31:0] PAUSE_TOP  = PAUSE_EN ? CyclesPause - 32'd1 : '0;

  traffic_state_e        state, state_next;
  logic [31:0]           active_cnt, active_cnt_next;
  logic [31:0]           pause_cnt, pause_cnt_next;
  logic                  running;  // low only until the first edge after reset
  logic                  tvalid;
  logic                  accept;
  logic [TDataWidth-1:0] tdata;
  logic [TIdWidth-1:0]   tid;
  logic                  tlast_pos;
  logic                  last_transfer, last_packet, last_frame, last_stream;

  assign tvalid = running && (state == ST_ACTIVE);
  assign accept = tvalid && m_axis_tready_i;

  axi4_stream_position_counter #(
    .TransfersPerPacket (TransfersPerPacket),
    .PacketsPerFrame    (PacketsPerFrame),
    .FramesPerStream    (FramesPerStream)
  ) u_position (
    .clk           (clk_m_axis_i),
    .rst_n         (rst_m_axis_ni),
    .step          (accept),
    .last_transfer (last_transfer),
    .last_packet   (last_packet),
    .last_frame    (last_frame),
    .last_stream   (last_stream)
  );

  // NOTE: every output of this block is given a default first, so no path
  // through the case leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_next      = state;
    active_cnt_next = active_cnt;
    pause_cnt_next  = pause_cnt;
    unique case (state)
      ST_ACTIVE: begin
        // An expired window waits for the pending transfer before pausing.
        if (PAUSE_EN && tvalid) begin
          if (active_cnt != '0) begin
            active_cnt_next = active_cnt - 32'd1;
          end else if (accept) begin
            state_next     = ST_PAUSE;
            pause_cnt_next = PAUSE_TOP;
          end
        end
      end
      ST_PAUSE: begin
        if (pause_cnt != '0) begin
          pause_cnt_next = pause_cnt - 32'd1;
        end else begin
          state_next      = ST_ACTIVE;
          active_cnt_next = ACTIVE_TOP;
        end
      end
      ST_DONE:  state_next = ST_DONE;
      default:  state_next = ST_ACTIVE;
    endcase
    if (SINGLE_EN && accept && last_stream) begin
      state_next = ST_DONE;
    end
  end

  always_ff @(posedge clk_m_axis_i or negedge rst_m_axis_ni) begin
    if (!rst_m_axis_ni) begin
      state      <= ST_ACTIVE;
      active_cnt <= ACTIVE_TOP;
      pause_cnt  <= PAUSE_TOP;
      running    <= 1'b0;
    end else begin
      state      <= state_next;
      active_cnt <= active_cnt_next;
      pause_cnt  <= pause_cnt_next;
      running    <= 1'b1;
    end
  end

  // tdata keeps counting across looped streams; only reset restarts it.
  always_ff @(posedge clk_m_axis_i or negedge rst_m_axis_ni) begin
    if (!rst_m_axis_ni) begin
      tdata <= TDATA_INIT;
      tid   <= TID_INIT;
    end else if (accept) begin
      tdata <= tdata + TDATA_INCR;
      if (last_stream) begin
        tid <= tid + TIdWidth'(1);
      end
    end
  end

  always_comb begin
    tlast_pos = 1'b0;
    if (TlastTrigger == TLAST_TRANSFER)    tlast_pos = 1'b1;
    else if (TlastTrigger == TLAST_PACKET) tlast_pos = last_transfer;
    else if (TlastTrigger == TLAST_FRAME)  tlast_pos = last_transfer & last_packet;
    else if (TlastTrigger == TLAST_STREAM) tlast_pos = last_transfer & last_packet & last_frame;
  end

  assign m_axis_tvalid_o = tvalid;
  assign m_axis_tdata_o  = tdata;
  assign m_axis_tlast_o  = tvalid & tlast_pos;
  assign m_axis_tid_o    = tid;
  assign m_axis_tdest_o  = TDestWidth'(TDest);
  assign done_o          = (state == ST_DONE);

`ifdef AXI4_STREAM_INITIATOR_TYPE_1_DEBUG_DISPLAY_EN
  always_ff @(posedge clk_m_axis_i) begin
    if (rst_m_axis_ni && accept) begin
      $display("@A4SI_T1 tdata=%h tid=%h tdest=%h tlast=%b",
               tdata, tid, m_axis_tdest_o, m_axis_tlast_o);
    end
    if (rst_m_axis_ni && state != ST_DONE && state_next == ST_DONE) begin
      $display("@A4SI_T1 SINGLE stream sent");
    end
  end
`else
  // Silent build: no console output, identical signal behaviour.
`endif

endmodule
